// File: rtl/hs32_xmem_pkg.sv
// Shared execute-unit constants for the load/store sequencer:
// access-size encodings, fault codes and sequencer states.
package hs32_xmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'b00,
    FLT_MISALIGN = 2'b01,
    FLT_TIMEOUT  = 2'b10,
    FLT_SIZE     = 2'b11
  } fault_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/hs32_xmem_lane.sv
// Byte-lane steering: byte enables, store placement, and load extraction
// with sign/zero extension for a DW-bit memory bus.
module hs32_lane #(
  parameter int DW = 32
) (
  input  logic [1:0]               size,
  input  logic                     sext,
  input  logic [$clog2(DW/8)-1:0]  off,
  input  logic [DW-1:0]            wdata,
  input  logic [DW-1:0]            rdata_raw,
  output logic [DW/8-1:0]          be,
  output logic [DW-1:0]            dtw,
  output logic [DW-1:0]            ldata
);

  localparam int NB = DW / 8;

  int            nbytes;
  int            nbits;
  logic [DW-1:0] shifted;
  logic          sign;

  always_comb begin
    nbytes  = 1 << size;
    nbits   = (nbytes * 8 > DW) ? DW : nbytes * 8;
    be      = '0;
    dtw     = wdata << {off, 3'b000};
    shifted = rdata_raw >> {off, 3'b000};
    sign    = 1'b0;
    ldata   = '0;
    for (int i = 0; i < NB; i++) begin
      if (i >= int'(off) && i < int'(off) + nbytes) be[i] = 1'b1;
    end
    for (int i = 0; i < DW; i++) begin
      if (i == nbits - 1) sign = sext & shifted[i];
    end
    // A full-width access has no bits above nbits, so sext has no effect.
    for (int i = 0; i < DW; i++) begin
      ldata[i] = (i < nbits) ? shifted[i] : sign;
    end
  end

endmodule

// File: rtl/hs32_xmem.sv
// Load/store sequencer between execute and the memory arbiter: one access
// per request, with lane placement, extension, alignment and timeout faults.
module hs32_xmem
  import hs32_xmem_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  output logic            rdy,
  input  logic            rw,
  input  logic [1:0]      size,
  input  logic            sext,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic            done,
  output logic [DW-1:0]   rdata,
  output logic [1:0]      fault,
  output logic [AW-1:0]   addr_m,
  output logic [DW-1:0]   dtw,
  output logic [DW/8-1:0] be,
  output logic            reqm,
  output logic            rw_mem,
  input  logic [DW-1:0]   dtrm,
  input  logic            rdym
);

  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_e          state, state_d;
  logic            rw_q;
  logic [1:0]      size_q;
  logic            sext_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [CW-1:0]   wait_cnt;
  logic            accept;
  logic            capture;
  logic [1:0]      fault_d;
  logic [3:0]      size_bytes;
  logic            size_illegal;
  logic            misaligned;
  logic [NB-1:0]   lane_be;
  logic [DW-1:0]   lane_dtw;
  logic [DW-1:0]   lane_ldata;

  assign rdy          = (state == ST_IDLE) && !reset;
  assign accept       = req && rdy;
  assign size_bytes   = 4'd1 << size;
  assign size_illegal = int'(size_bytes) > NB;
  assign misaligned   = |(addr[2:0] & 3'(size_bytes - 4'd1));

  always_comb begin
    state_d = state;
    fault_d = FLT_NONE;
    capture = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (size_illegal) begin
            state_d = ST_DONE;
            fault_d = FLT_SIZE;
          end else if (misaligned) begin
            state_d = ST_DONE;
            fault_d = FLT_MISALIGN;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (rdym) begin
          state_d = ST_DONE;
          capture = 1'b1;
        end else if (TIMEOUT != 0 && wait_cnt == CNT_LAST) begin
          state_d = ST_DONE;
          fault_d = FLT_TIMEOUT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  // Request fields are latched once at accept and drive the bus for the
  // whole REQ phase; results are latched on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      rw_q     <= 1'b0;
      size_q   <= 2'b00;
      sext_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wait_cnt <= '0;
      rdata    <= '0;
      fault    <= FLT_NONE;
    end else begin
      if (accept) begin
        rw_q     <= rw;
        size_q   <= size;
        sext_q   <= sext;
        addr_q   <= addr;
        wdata_q  <= wdata;
        wait_cnt <= '0;
      end else if (state == ST_REQ && !rdym && TIMEOUT != 0) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      if (state_d == ST_DONE && state != ST_DONE) begin
        fault <= fault_d;
        rdata <= (capture && !rw_q) ? lane_ldata : '0;
      end
    end
  end

  hs32_lane #(.DW(DW)) u_lane (
    .size      (size_q),
    .sext      (sext_q),
    .off       (addr_q[OW-1:0]),
    .wdata     (wdata_q),
    .rdata_raw (dtrm),
    .be        (lane_be),
    .dtw       (lane_dtw),
    .ldata     (lane_ldata)
  );

  assign reqm   = (state == ST_REQ);
  assign rw_mem = reqm && rw_q;
  assign done   = (state == ST_DONE);
  assign addr_m = reqm ? {addr_q[AW-1:OW], {OW{1'b0}}} : '0;
  assign be     = reqm ? lane_be : '0;
  assign dtw    = reqm ? lane_dtw : '0;

endmodule

// File: tb/tb_hs32_xmem.sv
// Bench for hs32_xmem: three instances (DW32/TIMEOUT4, DW32/TIMEOUT0,
// DW64/TIMEOUT255) driven from one vector table with a scoreboard queue.
module tb_hs32_xmem;

  typedef struct {
    int          sel;
    logic        rw;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] dtrm;
    int          resp_after;
    logic [31:0] e_addr_m;
    logic [7:0]  e_be;
    logic [63:0] e_dtw;
    logic        e_rw_mem;
    logic [63:0] e_rdata;
    logic [1:0]  e_fault;
    int          e_done;
    int          e_reqm;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        rw = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sext = 1'b0;
  logic [31:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [63:0] dtrm = '0;
  logic        rdym = 1'b0;
  int          sel = 0;

  logic        req_a, req_b, req_c;
  logic        rdy_a, rdy_b, rdy_c;
  logic        done_a, done_b, done_c;
  logic        reqm_a, reqm_b, reqm_c;
  logic        rwm_a, rwm_b, rwm_c;
  logic [1:0]  fault_a, fault_b, fault_c;
  logic [31:0] rdata_a, rdata_b;
  logic [63:0] rdata_c;
  logic [31:0] addrm_a, addrm_b, addrm_c;
  logic [31:0] dtw_a, dtw_b;
  logic [63:0] dtw_c;
  logic [3:0]  be_a, be_b;
  logic [7:0]  be_c;

  logic        m_rdy, m_done, m_reqm, m_rw_mem;
  logic [1:0]  m_fault;
  logic [63:0] m_rdata, m_dtw;
  logic [31:0] m_addr_m;
  logic [7:0]  m_be;

  int   checks = 0;
  int   passes = 0;
  vec_t sb[$];
  vec_t vecs[15];

  always #5 clk = ~clk;

  assign req_a = req && (sel == 0);
  assign req_b = req && (sel == 1);
  assign req_c = req && (sel == 2);

  hs32_xmem #(.DW(32), .AW(32), .TIMEOUT(4)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .rdy(rdy_a), .rw(rw), .size(size),
    .sext(sext), .addr(addr), .wdata(wdata[31:0]), .done(done_a), .rdata(rdata_a),
    .fault(fault_a), .addr_m(addrm_a), .dtw(dtw_a), .be(be_a), .reqm(reqm_a),
    .rw_mem(rwm_a), .dtrm(dtrm[31:0]), .rdym(rdym)
  );

  hs32_xmem #(.DW(32), .AW(32), .TIMEOUT(0)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .rdy(rdy_b), .rw(rw), .size(size),
    .sext(sext), .addr(addr), .wdata(wdata[31:0]), .done(done_b), .rdata(rdata_b),
    .fault(fault_b), .addr_m(addrm_b), .dtw(dtw_b), .be(be_b), .reqm(reqm_b),
    .rw_mem(rwm_b), .dtrm(dtrm[31:0]), .rdym(rdym)
  );

  hs32_xmem #(.DW(64), .AW(32), .TIMEOUT(255)) dut_c (
    .clk(clk), .reset(reset), .req(req_c), .rdy(rdy_c), .rw(rw), .size(size),
    .sext(sext), .addr(addr), .wdata(wdata), .done(done_c), .rdata(rdata_c),
    .fault(fault_c), .addr_m(addrm_c), .dtw(dtw_c), .be(be_c), .reqm(reqm_c),
    .rw_mem(rwm_c), .dtrm(dtrm), .rdym(rdym)
  );

  assign m_rdy    = (sel == 0) ? rdy_a   : (sel == 1) ? rdy_b   : rdy_c;
  assign m_done   = (sel == 0) ? done_a  : (sel == 1) ? done_b  : done_c;
  assign m_reqm   = (sel == 0) ? reqm_a  : (sel == 1) ? reqm_b  : reqm_c;
  assign m_rw_mem = (sel == 0) ? rwm_a   : (sel == 1) ? rwm_b   : rwm_c;
  assign m_fault  = (sel == 0) ? fault_a : (sel == 1) ? fault_b : fault_c;
  assign m_addr_m = (sel == 0) ? addrm_a : (sel == 1) ? addrm_b : addrm_c;
  assign m_rdata  = (sel == 0) ? {32'h0, rdata_a} : (sel == 1) ? {32'h0, rdata_b} : rdata_c;
  assign m_dtw    = (sel == 0) ? {32'h0, dtw_a}   : (sel == 1) ? {32'h0, dtw_b}   : dtw_c;
  assign m_be     = (sel == 0) ? {4'h0, be_a}     : (sel == 1) ? {4'h0, be_b}     : be_c;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Drives one request, answers the bus after resp_after REQ cycles, and
  // compares the bus and completion against the scoreboard entry.
  task automatic applyStimulus(input vec_t v);
    int   reqm_cnt;
    int   done_at;
    vec_t e;
    reqm_cnt = 0;
    done_at  = -1;
    @(negedge clk);
    sel   = v.sel;
    rw    = v.rw;
    size  = v.size;
    sext  = v.sext;
    addr  = v.addr;
    wdata = v.wdata;
    req   = 1'b1;
    sb.push_back(v);
    checkOutput("rdy_before_accept", {63'h0, m_rdy}, 64'd1);
    @(posedge clk);
    #1 req = 1'b0;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      rdym = 1'b0;
      if (m_done) begin
        done_at = k;
        break;
      end
      if (m_reqm) begin
        if (reqm_cnt == 0) begin
          checkOutput("addr_m", {32'h0, m_addr_m}, {32'h0, sb[0].e_addr_m});
          checkOutput("be", {56'h0, m_be}, {56'h0, sb[0].e_be});
          checkOutput("rw_mem", {63'h0, m_rw_mem}, {63'h0, sb[0].e_rw_mem});
          if (sb[0].rw) checkOutput("dtw", m_dtw, sb[0].e_dtw);
        end
        if (reqm_cnt == sb[0].resp_after) begin
          rdym = 1'b1;
          dtrm = sb[0].dtrm;
        end
        reqm_cnt++;
      end
    end
    e = sb.pop_front();
    checkOutput("done_cycle", 64'(done_at), 64'(e.e_done));
    checkOutput("reqm_cycles", 64'(reqm_cnt), 64'(e.e_reqm));
    if (done_at >= 0) begin
      checkOutput("fault", {62'h0, m_fault}, {62'h0, e.e_fault});
      if (!e.rw) checkOutput("rdata", m_rdata, e.e_rdata);
      @(negedge clk);
      checkOutput("rdy_after_done", {63'h0, m_rdy}, 64'd1);
      checkOutput("done_one_cycle", {63'h0, m_done}, 64'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int done_cnt;
    //        sel rw    size   sext  addr        wdata                  dtrm                   rsp   addr_m      be     dtw                    rw_m  rdata                  fault  done  reqm
    vecs[0]  = '{0, 1'b0, 2'd2, 1'b0, 32'h104, 64'h0,                 64'hDEADBEEF,          0,    32'h104, 8'h0F, 64'h0,                 1'b0, 64'hDEADBEEF,          2'd0,  1,    1};
    vecs[1]  = '{0, 1'b0, 2'd0, 1'b1, 32'h103, 64'h0,                 64'h80000000,          0,    32'h100, 8'h08, 64'h0,                 1'b0, 64'hFFFFFF80,          2'd0,  1,    1};
    vecs[2]  = '{0, 1'b0, 2'd0, 1'b0, 32'h103, 64'h0,                 64'h80000000,          0,    32'h100, 8'h08, 64'h0,                 1'b0, 64'h00000080,          2'd0,  1,    1};
    vecs[3]  = '{0, 1'b1, 2'd1, 1'b0, 32'h202, 64'h0000ABCD,          64'h0,                 0,    32'h200, 8'h0C, 64'hABCD0000,          1'b1, 64'h0,                 2'd0,  1,    1};
    vecs[4]  = '{0, 1'b0, 2'd1, 1'b0, 32'h201, 64'h0,                 64'h0,                 0,    32'h0,   8'h00, 64'h0,                 1'b0, 64'h0,                 2'd1,  0,    0};
    vecs[5]  = '{0, 1'b0, 2'd3, 1'b0, 32'h100, 64'h0,                 64'h0,                 0,    32'h0,   8'h00, 64'h0,                 1'b0, 64'h0,                 2'd3,  0,    0};
    vecs[6]  = '{0, 1'b0, 2'd2, 1'b0, 32'h300, 64'h0,                 64'h0,                 -1,   32'h300, 8'h0F, 64'h0,                 1'b0, 64'h0,                 2'd2,  4,    4};
    vecs[7]  = '{0, 1'b0, 2'd1, 1'b1, 32'h106, 64'h0,                 64'h80010000,          0,    32'h104, 8'h0C, 64'h0,                 1'b0, 64'hFFFF8001,          2'd0,  1,    1};
    vecs[8]  = '{0, 1'b1, 2'd0, 1'b0, 32'h101, 64'h5A,                64'h0,                 0,    32'h100, 8'h02, 64'h5A00,              1'b1, 64'h0,                 2'd0,  1,    1};
    vecs[9]  = '{0, 1'b1, 2'd2, 1'b0, 32'h102, 64'h11223344,          64'h0,                 0,    32'h0,   8'h00, 64'h0,                 1'b0, 64'h0,                 2'd1,  0,    0};
    vecs[10] = '{1, 1'b0, 2'd2, 1'b0, 32'h40,  64'h0,                 64'h12345678,          1000, 32'h40,  8'h0F, 64'h0,                 1'b0, 64'h12345678,          2'd0,  1001, 1001};
    vecs[11] = '{2, 1'b0, 2'd3, 1'b1, 32'h8,   64'h0,                 64'h0123456789ABCDEF,  0,    32'h8,   8'hFF, 64'h0,                 1'b0, 64'h0123456789ABCDEF,  2'd0,  1,    1};
    vecs[12] = '{2, 1'b0, 2'd2, 1'b1, 32'h4,   64'h0,                 64'h8765432100000000,  0,    32'h0,   8'hF0, 64'h0,                 1'b0, 64'hFFFFFFFF87654321,  2'd0,  1,    1};
    vecs[13] = '{2, 1'b1, 2'd1, 1'b0, 32'h6,   64'hBEEF,              64'h0,                 0,    32'h0,   8'hC0, 64'hBEEF000000000000,  1'b1, 64'h0,                 2'd0,  1,    1};
    vecs[14] = '{2, 1'b0, 2'd3, 1'b0, 32'h4,   64'h0,                 64'h0,                 0,    32'h0,   8'h00, 64'h0,                 1'b0, 64'h0,                 2'd1,  0,    0};

    repeat (2) @(negedge clk);
    checkOutput("reset_rdy", {63'h0, rdy_a}, 64'd0);
    checkOutput("reset_reqm", {63'h0, reqm_a}, 64'd0);
    checkOutput("reset_done", {63'h0, done_a}, 64'd0);
    checkOutput("reset_be_addr", {28'h0, be_a, addrm_a}, 64'd0);
    checkOutput("reset_rdata_fault", {30'h0, fault_a, rdata_a}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rdy_after_reset", {63'h0, rdy_a}, 64'd1);

    for (int i = 0; i < 15; i++) applyStimulus(vecs[i]);

    // Abort a pending load with reset in its second REQ cycle.
    @(negedge clk);
    sel  = 0;
    rw   = 1'b0;
    size = 2'd2;
    addr = 32'h500;
    req  = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    checkOutput("abort_reqm_1st", {63'h0, reqm_a}, 64'd1);
    @(negedge clk);
    checkOutput("abort_reqm_2nd", {63'h0, reqm_a}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_reqm_in_reset", {63'h0, reqm_a}, 64'd0);
    checkOutput("abort_rdy_in_reset", {63'h0, rdy_a}, 64'd0);
    reset = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done_a) done_cnt++;
    end
    checkOutput("abort_no_done", 64'(done_cnt), 64'd0);
    checkOutput("abort_rdy", {63'h0, rdy_a}, 64'd1);
    checkOutput("abort_reqm", {63'h0, reqm_a}, 64'd0);

    applyStimulus(vecs[0]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
